// File: rtl/rvv_vcfg_unit.sv
`default_nettype none
// ============================================================================
// rvv_vcfg_unit : vector configuration unit (vsetvli/vsetivli/vsetvl/vsetsh)
// Revision      : 1.0
// ============================================================================
module rvv_vcfg_unit #(
  parameter int unsigned VLEN     = 4096,
  parameter int unsigned ELEN     = 64,
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NR_SH_CH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [31:0]               instr_i,
  input  logic [XLEN-1:0]           rs1_i,
  input  logic [XLEN-1:0]           rs2_i,
  input  logic                      vec_idle_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [XLEN-1:0]           rsp_result_o,
  output logic                      rsp_illegal_o,
  output logic [$clog2(VLEN+1)-1:0] vl_o,
  output logic [XLEN-1:0]           vtype_o,
  output logic [NR_SH_CH*8-1:0]     sh_amt_o
);

  localparam int unsigned     VLW        = $clog2(VLEN + 1);
  localparam int              ELEN_LOG   = $clog2(ELEN);
  localparam logic [XLEN-1:0] VILL_VTYPE = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] NR_CH_X    = XLEN'(NR_SH_CH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  function automatic logic [VLW-1:0] calc_vlmax(input logic [2:0] sew, input logic [2:0] lmul);
    logic [VLW-1:0] base;
    base = VLW'(VLEN) >> ({2'b00, sew} + 5'd3);
    if (!lmul[2]) calc_vlmax = base << lmul[1:0];
    else          calc_vlmax = base >> (4'd8 - {1'b0, lmul});
  endfunction

  state_e                state_q, state_d;
  logic [31:0]           instr_q, instr_d;
  logic [XLEN-1:0]       rs1_q, rs1_d;
  logic [XLEN-1:0]       rs2_q, rs2_d;
  logic [VLW-1:0]        vl_q, vl_d;
  logic [XLEN-1:0]       vtype_q, vtype_d;
  logic [NR_SH_CH*8-1:0] sh_amt_q, sh_amt_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  illegal_q, illegal_d;

  logic            op_cfg, is_vli, is_vili, is_vl, is_sh;
  logic            illegal, keep_vl, vill_new, ch_ok, commit;
  logic [4:0]      rd, rs1_idx;
  logic [XLEN-1:0] vtype_raw, avl, vlmax_x, vtype_new;
  logic [VLW-1:0]  vlmax_new, vlmax_old, vl_new;
  logic [7:0]      sh_old;

  always_comb begin : decode
    rd      = instr_q[11:7];
    rs1_idx = instr_q[19:15];
    op_cfg  = (instr_q[6:0] == 7'h57) && (instr_q[14:12] == 3'b111);
    is_vli  = op_cfg && !instr_q[31];
    is_vili = op_cfg && (instr_q[31:30] == 2'b11);
    is_vl   = op_cfg && (instr_q[31:25] == 7'b1000000);
    is_sh   = op_cfg && (instr_q[31:28] == 4'b1010);

    vtype_raw = rs2_q;
    if (is_vli)       vtype_raw = {{(XLEN-11){1'b0}}, instr_q[30:20]};
    else if (is_vili) vtype_raw = {{(XLEN-10){1'b0}}, instr_q[29:20]};

    // SEW must fit in ELEN, and in ELEN*LMUL for fractional groupings
    vill_new = (|vtype_raw[XLEN-1:8]) || (vtype_raw[2:0] == 3'b100) ||
               (int'(vtype_raw[5:3]) + 3 > ELEN_LOG) ||
               (vtype_raw[2] && (int'(vtype_raw[5:3]) + 3 > ELEN_LOG - 8 + int'(vtype_raw[2:0])));

    vlmax_new = calc_vlmax(vtype_raw[5:3], vtype_raw[2:0]);
    vlmax_old = vtype_q[XLEN-1] ? '0 : calc_vlmax(vtype_q[5:3], vtype_q[2:0]);

    keep_vl = 1'b0;
    avl     = rs1_q;
    if (is_vili) begin
      avl = {{(XLEN-5){1'b0}}, rs1_idx};
    end else if (rs1_idx == 5'd0) begin
      if (rd != 5'd0) avl = '1;
      else            keep_vl = 1'b1;
    end
    if (keep_vl && (vlmax_new != vlmax_old)) vill_new = 1'b1;

    vlmax_x = {{(XLEN-VLW){1'b0}}, vlmax_new};
    if (vill_new) begin
      vtype_new = VILL_VTYPE;
      vl_new    = '0;
    end else begin
      vtype_new = vtype_raw;
      vl_new    = keep_vl ? vl_q : ((avl < vlmax_x) ? avl[VLW-1:0] : vlmax_new);
    end

    ch_ok  = rs1_q < NR_CH_X;
    sh_old = '0;
    for (int c = 0; c < NR_SH_CH; c++) begin
      if (rs1_q == XLEN'(c)) sh_old = sh_amt_q[8*c +: 8];
    end

    illegal = !(is_vli || is_vili || is_vl || is_sh) || (is_sh && !ch_ok);
  end

  always_comb begin : fsm
    state_d   = state_q;
    instr_d   = instr_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    vl_d      = vl_q;
    vtype_d   = vtype_q;
    sh_amt_d  = sh_amt_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    commit    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          instr_d = instr_i;
          rs1_d   = rs1_i;
          rs2_d   = rs2_i;
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (illegal) begin
          result_d  = '0;
          illegal_d = 1'b1;
          state_d   = ST_COMMIT;
        end else if (!is_sh && (vtype_new != vtype_q) && !vec_idle_i) begin
          state_d = ST_DRAIN;
        end else begin
          commit = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (vec_idle_i) commit = 1'b1;
      end
      ST_COMMIT: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Operands are held through DRAIN, so the decode results remain valid there
    if (commit) begin
      state_d   = ST_COMMIT;
      illegal_d = 1'b0;
      if (is_sh) begin
        result_d = {{(XLEN-8){1'b0}}, sh_old};
        for (int c = 0; c < NR_SH_CH; c++) begin
          if (rs1_q == XLEN'(c)) sh_amt_d[8*c +: 8] = instr_q[27:20];
        end
      end else begin
        vl_d     = vl_new;
        vtype_d  = vtype_new;
        result_d = {{(XLEN-VLW){1'b0}}, vl_new};
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      vl_q      <= '0;
      vtype_q   <= VILL_VTYPE;
      sh_amt_q  <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      vl_q      <= vl_d;
      vtype_q   <= vtype_d;
      sh_amt_q  <= sh_amt_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign req_ready_o   = (state_q == ST_IDLE);
  assign rsp_valid_o   = (state_q == ST_COMMIT);
  assign rsp_result_o  = result_q;
  assign rsp_illegal_o = illegal_q;
  assign vl_o          = vl_q;
  assign vtype_o       = vtype_q;
  assign sh_amt_o      = sh_amt_q;

endmodule
`default_nettype wire

// File: tb/tb_rvv_vcfg_unit.sv
`default_nettype none
// ============================================================================
// tb_rvv_vcfg_unit : scoreboard bench for the vector configuration unit
// Revision         : 1.0
// ============================================================================
module tb_rvv_vcfg_unit;

  localparam logic [63:0] VILL = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_valid;
  logic        req_ready_o;
  logic [31:0] instr;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic        vec_idle;
  logic        rsp_valid_o;
  logic        rsp_ready;
  logic [63:0] rsp_result_o;
  logic        rsp_illegal_o;
  logic [12:0] vl_o;
  logic [63:0] vtype_o;
  logic [31:0] sh_amt_o;

  rvv_vcfg_unit dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready_o),
    .instr_i      (instr),
    .rs1_i        (rs1),
    .rs2_i        (rs2),
    .vec_idle_i   (vec_idle),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready),
    .rsp_result_o (rsp_result_o),
    .rsp_illegal_o(rsp_illegal_o),
    .vl_o         (vl_o),
    .vtype_o      (vtype_o),
    .sh_amt_o     (sh_amt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] result;
    logic        illegal;
    logic [63:0] vl;
    logic [63:0] vtype;
    logic [31:0] sh;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   first_cyc = 0;
  bit   in_rsp   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic exp_t mk(input logic [63:0] r, input logic il, input logic [63:0] vl,
                              input logic [63:0] vt, input logic [31:0] sh, input int lat);
    exp_t e;
    e.result = r; e.illegal = il; e.vl = vl; e.vtype = vt; e.sh = sh; e.lat = lat;
    return e;
  endfunction

  function automatic logic [31:0] enc_vli(input logic [4:0] rd, input logic [4:0] rs1f, input logic [10:0] z);
    return {1'b0, z, rs1f, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] enc_vili(input logic [4:0] rd, input logic [4:0] u, input logic [9:0] z);
    return {2'b11, z, u, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] enc_vl(input logic [4:0] rd, input logic [4:0] rs1f, input logic [4:0] rs2f);
    return {7'b1000000, rs2f, rs1f, 3'b111, rd, 7'h57};
  endfunction
  function automatic logic [31:0] enc_sh(input logic [4:0] rd, input logic [4:0] rs1f, input logic [7:0] u);
    return {4'b1010, u, rs1f, 3'b111, rd, 7'h57};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin : mon
    exp_t e;
    int   fc;
    fc = in_rsp ? first_cyc : cyc;
    if (rsp_valid_o && !in_rsp) first_cyc <= cyc;
    if (rsp_valid_o && rsp_ready) begin
      in_rsp <= 1'b0;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("result",  rsp_result_o, e.result);
        check("illegal", 64'(rsp_illegal_o), 64'(e.illegal));
        check("vl",      64'(vl_o), e.vl);
        check("vtype",   vtype_o, e.vtype);
        check("sh_amt",  64'(sh_amt_o), 64'(e.sh));
        if (e.lat >= 0) check("latency", 64'(fc - acc_cyc), 64'(e.lat));
      end
    end else if (rsp_valid_o) begin
      in_rsp <= 1'b1;
    end
  end

  task automatic issue(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
    int n;
    n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; instr = ins; rs1 = a; rs2 = b;
    @(negedge clk);
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req_accept", 64'(req_ready_o), 64'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rsp_timeout", 64'(sb.size()), 64'd0);
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b, input exp_t e);
    sb.push_back(e);
    issue(ins, a, b);
    wait_rsp();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] bad;
    int          n;
    req_valid = 1'b0; instr = '0; rs1 = '0; rs2 = '0;
    vec_idle = 1'b1; rsp_ready = 1'b1; rst_ni = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready_o), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_vl",        64'(vl_o), 64'd0);
    check("rst_vtype",     vtype_o, VILL);
    check("rst_sh_amt",    64'(sh_amt_o), 64'd0);

    // vl = min(AVL, VLMAX) for several SEW/LMUL settings (VLEN 4096)
    send(enc_vli(5'd1, 5'd5, 11'h010), 64'd100,  64'd0, mk(64'd100,  1'b0, 64'd100,  64'h10, 32'h0, 2));
    send(enc_vli(5'd1, 5'd6, 11'h001), 64'd1000, 64'd0, mk(64'd1000, 1'b0, 64'd1000, 64'h01, 32'h0, 2));
    send(enc_vli(5'd1, 5'd6, 11'h001), 64'd5000, 64'd0, mk(64'd1024, 1'b0, 64'd1024, 64'h01, 32'h0, 2));
    send(enc_vli(5'd1, 5'd6, 11'h01D), 64'd10,   64'd0, mk(64'd0,    1'b0, 64'd0,    VILL,   32'h0, 2));
    send(enc_vli(5'd1, 5'd6, 11'h004), 64'd10,   64'd0, mk(64'd0,    1'b0, 64'd0,    VILL,   32'h0, 2));
    send(enc_vli(5'd1, 5'd0, 11'h010), 64'd999,  64'd0, mk(64'd128,  1'b0, 64'd128,  64'h10, 32'h0, 2));
    send(enc_vl (5'd1, 5'd7, 5'd8),    64'd50,   64'h01, mk(64'd50,  1'b0, 64'd50,   64'h01, 32'h0, 2));
    send(enc_vli(5'd0, 5'd0, 11'h00A), 64'd0,    64'd0, mk(64'd50,   1'b0, 64'd50,   64'h0A, 32'h0, 2));
    send(enc_vli(5'd0, 5'd0, 11'h010), 64'd0,    64'd0, mk(64'd0,    1'b0, 64'd0,    VILL,   32'h0, 2));
    send(enc_vl (5'd1, 5'd7, 5'd8),    64'd20,   64'h110, mk(64'd0,  1'b0, 64'd0,    VILL,   32'h0, 2));

    // vtype change while the vector unit is busy must wait for idle
    vec_idle = 1'b0;
    sb.push_back(mk(64'd17, 1'b0, 64'd17, 64'h0F, 32'h0, -1));
    issue(enc_vili(5'd1, 5'd17, 10'h00F), 64'd0, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("drain_hold", 64'(rsp_valid_o), 64'd0);
    end
    @(posedge clk); #1 vec_idle = 1'b1;
    wait_rsp();

    // same vtype and vsetsh never wait for drain
    vec_idle = 1'b0;
    send(enc_vili(5'd1, 5'd17, 10'h00F), 64'd0, 64'd0, mk(64'd17, 1'b0, 64'd17, 64'h0F, 32'h0, 2));
    send(enc_sh(5'd1, 5'd2, 8'h0C), 64'd2, 64'd0, mk(64'd0,    1'b0, 64'd17, 64'h0F, 32'h000C_0000, 2));
    send(enc_sh(5'd1, 5'd2, 8'h33), 64'd2, 64'd0, mk(64'h0C,   1'b0, 64'd17, 64'h0F, 32'h0033_0000, 2));
    send(enc_sh(5'd1, 5'd9, 8'h55), 64'd4, 64'd0, mk(64'd0,    1'b1, 64'd17, 64'h0F, 32'h0033_0000, 2));
    vec_idle = 1'b1;
    bad = enc_vli(5'd1, 5'd5, 11'h010);
    bad[14:12] = 3'b000;
    send(bad, 64'd9, 64'd0, mk(64'd0, 1'b1, 64'd17, 64'h0F, 32'h0033_0000, 2));

    // response back-pressure
    rsp_ready = 1'b0;
    sb.push_back(mk(64'd7, 1'b0, 64'd7, 64'h10, 32'h0033_0000, -1));
    issue(enc_vli(5'd1, 5'd5, 11'h010), 64'd7, 64'd0);
    n = 0;
    while (!rsp_valid_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_valid_seen", 64'(rsp_valid_o), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid",  64'(rsp_valid_o), 64'd1);
      check("hold_result", rsp_result_o, 64'd7);
      check("hold_ready",  64'(req_ready_o), 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_rsp();

    // reset while draining drops the instruction silently
    vec_idle = 1'b0;
    issue(enc_vli(5'd1, 5'd5, 11'h001), 64'd3, 64'd0);
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #2;
    check("arst_vl",        64'(vl_o), 64'd0);
    check("arst_vtype",     vtype_o, VILL);
    check("arst_sh_amt",    64'(sh_amt_o), 64'd0);
    check("arst_req_ready", 64'(req_ready_o), 64'd1);
    @(negedge clk);
    rst_ni = 1'b1;
    vec_idle = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_rsp_after_rst", 64'(rsp_valid_o), 64'd0);
    end

    send(enc_vli(5'd1, 5'd0, 11'h001), 64'd0, 64'd0, mk(64'd1024, 1'b0, 64'd1024, 64'h01, 32'h0, 2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
